// File: rtl/servo_pkg.sv
// servo_pkg: command and FSM encodings shared by the leg servo blocks.
package servo_pkg;
  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_HOME = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_STOP = 2'b10} state_t;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: wrapping frame counter with last-cycle flag, held at 0 when not running.
module frame_timer #(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last_o = run_i && cnt_q == LAST;
  assign cnt_o  = cnt_q;
  always_comb cnt_d = (!run_i || last_o) ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/leg_servo_pwm.sv
// leg_servo_pwm: per-joint servo pulse generator with a clamped position
// stepped once per frame by the selector command.
module leg_servo_pwm
  import servo_pkg::*;
#(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MIN_PULSE     = 50000,
  parameter int MAX_PULSE     = 100000,
  parameter int CENTER_PULSE  = 75000,
  parameter int STEP          = 500,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       cmd,
  output logic             pwmOut,
  output logic [CNT_W-1:0] position,
  output logic             frameTick,
  output logic             atLimit
);
  localparam int W = CNT_W + 1;
  localparam logic [W-1:0] MIN_W  = W'(MIN_PULSE);
  localparam logic [W-1:0] MAX_W  = W'(MAX_PULSE);
  localparam logic [W-1:0] CEN_W  = W'(CENTER_PULSE);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  if (!(MIN_PULSE <= CENTER_PULSE && CENTER_PULSE <= MAX_PULSE && MAX_PULSE < PERIOD_CYCLES)) begin : g_param_err
    $error("leg_servo_pwm: need MIN_PULSE <= CENTER_PULSE <= MAX_PULSE < PERIOD_CYCLES");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt, pos_q, pos_d;
  logic last;
  logic [W-1:0] p, up, dn, hm, nxt;
  frame_timer #(.PERIOD_CYCLES(PERIOD_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .run_i(state_q != S_IDLE), .cnt_o(cnt), .last_o(last)
  );
  always_comb begin
    state_d = state_q == S_IDLE ? (enable ? S_RUN : S_IDLE)
            : state_q == S_RUN  ? (enable ? S_RUN : S_STOP)
            : enable ? S_RUN : last ? S_IDLE : S_STOP;
  end
  // One extra bit of headroom means the step can never wrap before clamping.
  always_comb begin
    p     = {1'b0, pos_q};
    up    = p + STEP_W > MAX_W ? MAX_W : p + STEP_W;
    dn    = p < MIN_W + STEP_W ? MIN_W : p - STEP_W;
    hm    = p > CEN_W ? (p - CEN_W <= STEP_W ? CEN_W : p - STEP_W)
                      : (CEN_W - p <= STEP_W ? CEN_W : p + STEP_W);
    nxt   = cmd == CMD_INC ? up : cmd == CMD_DEC ? dn : cmd == CMD_HOME ? hm : p;
    pos_d = last ? nxt[CNT_W-1:0] : pos_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? S_IDLE : state_d;
    pos_q   <= rst ? CNT_W'(CENTER_PULSE) : pos_d;
  end
  assign pwmOut    = state_q != S_IDLE && cnt < pos_q;
  assign frameTick = last;
  assign position  = pos_q;
  assign atLimit   = pos_q == MIN_W[CNT_W-1:0] || pos_q == MAX_W[CNT_W-1:0];
endmodule
